// File: rtl/qspi_bus_arbiter.sv
// qspi_bus_arbiter: shares one QSPI master engine between two requesters.
// Port 0 (XIP instruction fetch) has fixed priority. A saturating starvation
// counter forces a port-1 grant after MAX_WAIT back-to-back port-0 grants
// made while port 1 was waiting. One command is latched per grant. It is
// offered to the engine and the arbiter then waits for completion or a
// timeout. The result is routed back to the owning requester.
//
// Engine handshake: eng_valid_o rises with the latched command and holds it
// stable until a cycle where eng_ready_i is also high. That cycle transfers
// the command. eng_valid_o drops on the following cycle and never
// re-asserts for the same command.
//
// All outputs come straight from flops. No input reaches an output
// combinationally.
module qspi_bus_arbiter #(
  parameter int ADDR_W   = 24,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8,
  parameter int TIMEOUT  = 4096
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              m0_req_i,
  input  logic [7:0]        m0_cmd_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  input  logic              m0_we_i,
  output logic              m0_gnt_o,
  output logic              m0_done_o,
  output logic              m0_err_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m1_req_i,
  input  logic [7:0]        m1_cmd_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  input  logic              m1_we_i,
  output logic              m1_gnt_o,
  output logic              m1_done_o,
  output logic              m1_err_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              eng_valid_o,
  input  logic              eng_ready_i,
  output logic [7:0]        eng_cmd_o,
  output logic [ADDR_W-1:0] eng_addr_o,
  output logic [DATA_W-1:0] eng_wdata_o,
  output logic              eng_we_o,
  input  logic              eng_done_i,
  input  logic [DATA_W-1:0] eng_rdata_i,
  output logic              busy_o,
  output logic              owner_o,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  localparam int SW = $clog2(MAX_WAIT + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_WAIT);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            owner_d, valid_d, busy_d;
  logic            gnt0_d, gnt1_d, done0_d, done1_d, err0_d, err1_d;
  logic            load_cmd, load_rd0, load_rd1;
  logic            win1;

  assign dbg_state_o = state_q;

  // Port 1 wins when it is alone, or when port 0 has used up its quota.
  assign win1 = m1_req_i & (~m0_req_i | (starve_q == STARVE_MAX));

  // Next-state and next-output decisions; everything is registered below.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    tmo_d    = tmo_q;
    owner_d  = owner_o;
    valid_d  = eng_valid_o;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    load_cmd = 1'b0;
    load_rd0 = 1'b0;
    load_rd1 = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_req_i || m1_req_i) begin
          state_d  = ISSUE;
          load_cmd = 1'b1;
          owner_d  = win1;
          valid_d  = 1'b1;
          gnt0_d   = ~win1;
          gnt1_d   = win1;
          // Quota only accumulates while port 1 is actually being held off.
          if (win1 || !m1_req_i) begin
            starve_d = '0;
          end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + SW'(1);
          end
        end
      end
      ISSUE: begin
        if (eng_ready_i) begin
          state_d = WAIT_DONE;
          valid_d = 1'b0;
          tmo_d   = '0;
        end
      end
      WAIT_DONE: begin
        // A done arriving on the expiry cycle still counts as success.
        if (eng_done_i) begin
          state_d  = IDLE;
          done0_d  = ~owner_o;
          done1_d  = owner_o;
          load_rd0 = ~owner_o;
          load_rd1 = owner_o;
        end else if (tmo_q == TMO_LAST) begin
          state_d = IDLE;
          done0_d = ~owner_o;
          done1_d = owner_o;
          err0_d  = ~owner_o;
          err1_d  = owner_o;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, counters and control/status outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      tmo_q       <= '0;
      owner_o     <= 1'b0;
      eng_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      m0_gnt_o    <= 1'b0;
      m1_gnt_o    <= 1'b0;
      m0_done_o   <= 1'b0;
      m1_done_o   <= 1'b0;
      m0_err_o    <= 1'b0;
      m1_err_o    <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      tmo_q       <= tmo_d;
      owner_o     <= owner_d;
      eng_valid_o <= valid_d;
      busy_o      <= busy_d;
      m0_gnt_o    <= gnt0_d;
      m1_gnt_o    <= gnt1_d;
      m0_done_o   <= done0_d;
      m1_done_o   <= done1_d;
      m0_err_o    <= err0_d;
      m1_err_o    <= err1_d;
    end
  end

  // Command latch: captures the winner's fields on the grant cycle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      eng_cmd_o   <= '0;
      eng_addr_o  <= '0;
      eng_wdata_o <= '0;
      eng_we_o    <= 1'b0;
    end else if (load_cmd) begin
      eng_cmd_o   <= win1 ? m1_cmd_i   : m0_cmd_i;
      eng_addr_o  <= win1 ? m1_addr_i  : m0_addr_i;
      eng_wdata_o <= win1 ? m1_wdata_i : m0_wdata_i;
      eng_we_o    <= win1 ? m1_we_i    : m0_we_i;
    end
  end

  // Read data return: only a successful completion updates the owner's word.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      m0_rdata_o <= '0;
      m1_rdata_o <= '0;
    end else begin
      if (load_rd0) m0_rdata_o <= eng_rdata_i;
      if (load_rd1) m1_rdata_o <= eng_rdata_i;
    end
  end

endmodule

// File: tb/tb_qspi_bus_arbiter.sv
// Bench for qspi_bus_arbiter: directed transaction table, hand-written
// corner sequences (timeout, reset mid-transaction, stray done) and a
// randomized stream checked against a transaction-level arbitration model.
module tb_qspi_bus_arbiter;

  localparam int ADDR_W   = 24;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 8;
  localparam int TIMEOUT  = 16;
  localparam int FW       = 1 + 8 + ADDR_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              m0_req, m0_we, m1_req, m1_we;
  logic [7:0]        m0_cmd, m1_cmd;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic              m0_gnt_o, m0_done_o, m0_err_o, m1_gnt_o, m1_done_o, m1_err_o;
  logic [DATA_W-1:0] m0_rdata_o, m1_rdata_o;
  logic              eng_valid_o, eng_ready, eng_we_o, eng_done;
  logic [7:0]        eng_cmd_o;
  logic [ADDR_W-1:0] eng_addr_o;
  logic [DATA_W-1:0] eng_wdata_o, eng_rdata;
  logic              busy_o, owner_o;
  logic [1:0]        dbg_state_o;

  qspi_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .reset_i(reset),
    .m0_req_i(m0_req), .m0_cmd_i(m0_cmd), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_we_i(m0_we),
    .m0_gnt_o(m0_gnt_o), .m0_done_o(m0_done_o), .m0_err_o(m0_err_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req), .m1_cmd_i(m1_cmd), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_we_i(m1_we),
    .m1_gnt_o(m1_gnt_o), .m1_done_o(m1_done_o), .m1_err_o(m1_err_o), .m1_rdata_o(m1_rdata_o),
    .eng_valid_o(eng_valid_o), .eng_ready_i(eng_ready), .eng_cmd_o(eng_cmd_o), .eng_addr_o(eng_addr_o),
    .eng_wdata_o(eng_wdata_o), .eng_we_o(eng_we_o), .eng_done_i(eng_done), .eng_rdata_i(eng_rdata),
    .busy_o(busy_o), .owner_o(owner_o), .dbg_state_o(dbg_state_o)
  );

  wire [8:0]    ctrl_o   = {m0_gnt_o, m1_gnt_o, m0_done_o, m1_done_o, m0_err_o, m1_err_o,
                            eng_valid_o, busy_o, owner_o};
  wire [FW-1:0] fields_o = {eng_we_o, eng_cmd_o, eng_addr_o, eng_wdata_o};

  // ---------------- scoreboard state ----------------
  int checks;
  int failures;
  logic [DATA_W+1:0] exp_q[$];   // {port, err, rdata}
  logic [FW-1:0]     fld[2];
  logic [DATA_W-1:0] last_rdata[2];

  typedef struct {
    logic          r0, r1;
    logic [FW-1:0] f0, f1;
    int            rdy, dly;
    logic [31:0]   rdata;
    int            win;
  } vec_t;
  vec_t tbl[9];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] mkf(input logic we, input logic [7:0] cmd,
                                        input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd);
    return {we, cmd, addr, wd};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_port(input int p, input logic req, input logic [FW-1:0] f);
    fld[p] = f;
    if (p == 0) begin
      m0_req = req;
      {m0_we, m0_cmd, m0_addr, m0_wdata} = f;
    end else begin
      m1_req = req;
      {m1_we, m1_cmd, m1_addr, m1_wdata} = f;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_port(0, 1'b0, '0);
    set_port(1, 1'b0, '0);
    eng_ready = 1'b0;
    eng_done  = 1'b0;
    eng_rdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    last_rdata[0] = '0;
    last_rdata[1] = '0;
    exp_q.delete();
  endtask

  // Pops the scoreboard on a done pulse and compares port, err and data.
  task automatic sb_done();
    logic [DATA_W+1:0] got, exp;
    got = {m1_done_o, m0_err_o | m1_err_o, m1_done_o ? m1_rdata_o : m0_rdata_o};
    check("done_onehot", m0_done_o ^ m1_done_o, 1'b1);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_underflow: done with no expected entry, got %0h", got);
    end else begin
      exp = exp_q.pop_front();
      check("done_content", got, exp);
    end
  endtask

  task automatic grant_check(input int win);
    check("gnt0", m0_gnt_o, win == 0);
    check("gnt1", m1_gnt_o, win == 1);
    check("owner", owner_o, win == 1);
    check("busy_on_gnt", busy_o, 1'b1);
    check("valid_on_gnt", eng_valid_o, 1'b1);
    check("eng_fields", fields_o, fld[win]);
  endtask

  // Drives the engine side from the grant cycle to the done pulse.
  task automatic complete(input int p, input int rdy, input int dly, input logic [DATA_W-1:0] rd);
    int bad;
    bad = 0;
    repeat (rdy) begin
      step();
      if (!eng_valid_o || fields_o !== fld[p] || m0_gnt_o || m1_gnt_o || !busy_o) bad++;
    end
    check("issue_hold", bad, 0);
    eng_ready = 1'b1;
    step();
    eng_ready = 1'b0;
    check("valid_drop", eng_valid_o, 1'b0);
    bad = 0;
    repeat (dly) begin
      step();
      if (m0_done_o || m1_done_o || eng_valid_o) bad++;
    end
    check("wait_quiet", bad, 0);
    eng_done  = 1'b1;
    eng_rdata = rd;
    exp_q.push_back({p[0], 1'b0, rd});
    step();
    eng_done  = 1'b0;
    eng_rdata = $urandom;
    last_rdata[p] = rd;
    sb_done();
    check("other_rdata_held", (p == 1) ? m0_rdata_o : m1_rdata_o, last_rdata[1-p]);
    check("idle_after_done", busy_o, 1'b0);
    step();
    check("done_pulse_len", {m0_done_o, m1_done_o}, 2'b00);
  endtask

  task automatic run_txn(input vec_t v);
    set_port(0, v.r0, v.f0);
    set_port(1, v.r1, v.f1);
    step();
    grant_check(v.win);
    m0_req = 1'b0;
    m1_req = 1'b0;
    complete(v.win, v.rdy, v.dly, v.rdata);
  endtask

  // Randomized stream. The model grants port 1 when it is alone, or when
  // port 0 has already won MAX_WAIT times in a row while port 1 waited.
  task automatic run_stream(input int ncyc, input bit forced);
    bit            inflight, expect_gnt, expect_done;
    bit [1:0]      r;
    logic [FW-1:0] f[2];
    int            phase, cnt, streak, owner, ngrant, exp_w;
    inflight = 0; expect_gnt = 0; expect_done = 0;
    r = 2'b00; phase = 0; cnt = 0; streak = 0; owner = 0; ngrant = 0;
    f[0] = '0; f[1] = '0;
    for (int c = 0; c < ncyc; c++) begin
      step();
      eng_ready = 1'b0;
      eng_done  = 1'b0;
      eng_rdata = $urandom;
      check("gnt_presence", m0_gnt_o | m1_gnt_o, expect_gnt);
      if (m0_gnt_o || m1_gnt_o) begin
        exp_w = (r[0] && r[1]) ? ((streak >= MAX_WAIT) ? 1 : 0) : (r[1] ? 1 : 0);
        check("gnt_winner", {m1_gnt_o, m0_gnt_o}, (exp_w == 1) ? 2'b10 : 2'b01);
        if (forced) check("fair_order", m1_gnt_o, (ngrant % (MAX_WAIT + 1)) == MAX_WAIT);
        check("stream_fields", fields_o, f[exp_w]);
        check("stream_owner", owner_o, exp_w == 1);
        if (exp_w == 1 || !r[1]) streak = 0;
        else if (streak < MAX_WAIT) streak++;
        owner = exp_w;
        inflight = 1;
        r[exp_w] = 1'b0;
        ngrant++;
      end
      check("done_presence", m0_done_o | m1_done_o, expect_done);
      if (m0_done_o || m1_done_o) begin
        sb_done();
        inflight = 0;
      end
      expect_done = 0;
      // Engine responder.
      if (phase == 0 && eng_valid_o) begin
        phase = 1;
        cnt = $urandom_range(0, 3);
      end
      if (phase == 1) begin
        check("valid_hold", eng_valid_o, 1'b1);
        if (cnt == 0) begin
          eng_ready = 1'b1;
          phase = 2;
          cnt = $urandom_range(0, 5);
        end else cnt--;
      end else if (phase == 2) begin
        check("valid_low_wait", eng_valid_o, 1'b0);
        if (cnt == 0) begin
          eng_done  = 1'b1;
          eng_rdata = $urandom;
          exp_q.push_back({owner[0], 1'b0, eng_rdata});
          expect_done = 1;
          phase = 0;
        end else cnt--;
      end
      // Requesters: hold until granted, then optionally raise a new command.
      for (int p = 0; p < 2; p++) begin
        if (!r[p] && (forced || $urandom_range(0, 2) == 0)) begin
          r[p] = 1'b1;
          f[p] = {1'($urandom_range(0, 1)), 8'($urandom), 24'($urandom), 32'($urandom)};
        end
        set_port(p, r[p], f[p]);
      end
      expect_gnt = !inflight && (r[0] || r[1]);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    checks = 0;
    failures = 0;

    tbl[0] = '{1, 0, mkf(0, 8'hEB, 24'h001000, 32'h0), '0, 3, 2, 32'hDEADBEEF, 0};
    tbl[1] = '{0, 1, '0, mkf(1, 8'h02, 24'h000200, 32'h12345678), 10, 0, 32'h11110000, 1};
    tbl[2] = '{1, 1, mkf(0, 8'h6B, 24'h0A0000, 32'h0), mkf(1, 8'h32, 24'h0B0000, 32'hCAFE0001), 0, 1, 32'h00000002, 0};
    tbl[3] = '{1, 1, mkf(0, 8'hEB, 24'h0A0004, 32'h0), mkf(1, 8'h32, 24'h0B0000, 32'hCAFE0001), 1, 0, 32'h00000003, 0};
    tbl[4] = '{0, 1, '0, mkf(0, 8'h03, 24'hFFFFFF, 32'h0), 2, 3, 32'hA5A5A5A5, 1};
    tbl[5] = '{1, 1, mkf(1, 8'h02, 24'h000010, 32'hFFFFFFFF), mkf(0, 8'h0B, 24'h123456, 32'h0), 0, 0, 32'h5A5A5A5A, 0};
    tbl[6] = '{1, 0, mkf(0, 8'hEB, 24'h000000, 32'h0), '0, 1, 1, 32'h00000000, 0};
    tbl[7] = '{1, 1, mkf(0, 8'hBB, 24'h800000, 32'h0), mkf(0, 8'h05, 24'h000001, 32'h0), 0, 2, 32'h87654321, 0};
    tbl[8] = '{0, 1, '0, mkf(0, 8'h9F, 24'h000000, 32'h0), 1, 4, 32'h00C22018, 1};

    do_reset();
    check("reset_ctrl", ctrl_o, 9'h0);
    check("reset_rdata", {m0_rdata_o, m1_rdata_o}, 64'h0);
    check("reset_fields", fields_o, '0);

    for (int i = 0; i < 9; i++) run_txn(tbl[i]);

    // Timeout: engine accepts but never completes.
    set_port(0, 1'b1, mkf(0, 8'hEB, 24'h00ABCD, 32'h0));
    step();
    grant_check(0);
    m0_req = 1'b0;
    eng_ready = 1'b1;
    step();
    eng_ready = 1'b0;
    exp_q.push_back({1'b0, 1'b1, last_rdata[0]});
    n = 0;
    while (!(m0_done_o || m1_done_o) && n < 40) begin
      step();
      n++;
    end
    check("tmo_latency", n, TIMEOUT);
    sb_done();
    step();
    check("tmo_pulse_len", {m0_done_o, m0_err_o, busy_o}, 3'b000);
    run_txn('{1, 0, mkf(0, 8'h0B, 24'h000100, 32'h0), '0, 0, 0, 32'h0BADF00D, 0});

    // Reset in WAIT_DONE with a port-0 request pending.
    set_port(1, 1'b1, mkf(0, 8'h6B, 24'h00F000, 32'h0));
    step();
    grant_check(1);
    m1_req = 1'b0;
    eng_ready = 1'b1;
    step();
    eng_ready = 1'b0;
    step();
    set_port(0, 1'b1, mkf(1, 8'h02, 24'h000040, 32'h0F0F0F0F));
    #2 reset = 1'b1;
    #1;
    check("rst_async_ctrl", ctrl_o, 9'h0);
    check("rst_async_rdata", {m0_rdata_o, m1_rdata_o}, 64'h0);
    check("rst_async_fields", fields_o, '0);
    @(negedge clk);
    reset = 1'b0;
    last_rdata[0] = '0;
    last_rdata[1] = '0;
    step();
    check("no_done_after_reset", m0_done_o | m1_done_o, 1'b0);
    grant_check(0);
    m0_req = 1'b0;
    complete(0, 0, 1, 32'hC0FFEE00);

    // Stray engine done in IDLE, then in ISSUE.
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    check("stray_idle", {busy_o, m0_done_o, m1_done_o, m0_gnt_o, m1_gnt_o}, 5'b0);
    set_port(0, 1'b1, mkf(0, 8'hEB, 24'h000800, 32'h0));
    step();
    grant_check(0);
    m0_req = 1'b0;
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    check("stray_issue", {busy_o, eng_valid_o, m0_done_o, m1_done_o}, 4'b1100);
    complete(0, 1, 1, 32'h13579BDF);

    do_reset();
    run_stream(300, 1'b1);
    do_reset();
    run_stream(2000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
